// File: rtl/rc_mon_pkg.sv
// Shared types and helpers for the RC step-response monitor and related model checkers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rc_mon_pkg;

   // Default width of every cycle counter in the monitor.
   localparam int RC_MON_CNT_W = 16;

   // Measurement sequencing: arm, wait for low crossing, wait for high crossing, settle, hold.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RISE_LO,
      ST_RISE_HI,
      ST_SETTLE,
      ST_DONE
   } rc_mon_state_t;

   // Converts a real value into a raw fixed-point integer (value = raw * 2^exponent),
   // intended for computing parameter values at elaboration time.
   function automatic longint rc_mon_to_raw(input real value, input int exponent);
      real scaled;
      scaled = value;
      if (exponent < 0) begin
         for (int i = 0; i < -exponent; i++) scaled = scaled * 2.0;
      end else begin
         for (int i = 0; i < exponent; i++) scaled = scaled / 2.0;
      end
      return longint'(scaled);
   endfunction

endpackage

// File: rtl/rc_mon_window.sv
// Signed window comparator: flags |value - centre| <= tol, evaluated one bit wider than the inputs.
// Latency: combinational.
// Backpressure: none.
module rc_mon_window #(
   parameter int WIDTH = 24
) (
   input  logic signed [WIDTH-1:0] value,
   input  logic signed [WIDTH-1:0] centre,
   input  logic signed [WIDTH-1:0] tol,
   output logic                    in_window
);

   logic signed [WIDTH:0] diff;
   logic        [WIDTH:0] mag;

   // Difference and magnitude at WIDTH+1 bits so no pair of WIDTH-bit inputs can overflow.
   always_comb begin
      diff      = {value[WIDTH-1], value} - {centre[WIDTH-1], centre};
      mag       = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
      in_window = (mag <= {1'b0, $unsigned(tol)});
   end

endmodule

// File: rtl/rc_step_monitor.sv
// Applies a step to an analog model and measures rise time, settling time and (RC_MON_PEAK_EN) peak.
// Latency: results and done register on the edge that takes the completing (or final timeout) sample.
// Backpressure: none; start is ignored while busy, results hold until the next accepted start.
module rc_step_monitor
   import rc_mon_pkg::*;
#(
   parameter int WIDTH         = 24,
   parameter int EXPONENT      = -16,
   parameter int STEP_LEVEL    = 65536,
   parameter int V_LO          = 6554,
   parameter int V_HI          = 58982,
   parameter int V_TOL         = 655,
   parameter int SETTLE_CYCLES = 8,
   parameter int MAX_CYCLES    = 4096,
   parameter int CNT_W         = RC_MON_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] v_in,
   output logic signed [WIDTH-1:0] v_drive,
   output logic                    busy,
   output logic                    done,
   output logic                    timeout,
   output logic        [CNT_W-1:0] rise_cycles,
   output logic        [CNT_W-1:0] settle_cycles,
   output logic signed [WIDTH-1:0] peak
);

   // Reject builds whose counters cannot reach the timeout or whose format cannot hold 1.0.
   if (MAX_CYCLES >= (1 << CNT_W) || -EXPONENT >= WIDTH - 1) begin : g_cfg_check
      $error("rc_step_monitor: MAX_CYCLES must fit CNT_W and 1.0 must be representable");
   end

   localparam logic signed [WIDTH-1:0] STEP_R   = WIDTH'(STEP_LEVEL);
   localparam logic signed [WIDTH-1:0] LO_TH    = WIDTH'(V_LO);
   localparam logic signed [WIDTH-1:0] HI_TH    = WIDTH'(V_HI);
   localparam logic signed [WIDTH-1:0] TOL_R    = WIDTH'(V_TOL);
   localparam logic        [CNT_W-1:0] LAST_C   = CNT_W'(MAX_CYCLES - 1);
   localparam logic        [CNT_W-1:0] RUN_DONE = CNT_W'(SETTLE_CYCLES);

   rc_mon_state_t    state, state_next;
   logic [CNT_W-1:0] c, c_lo, run, run_next;
   logic             in_win, lo_hit, hi_hit, measuring, accept, settled, expire;

   rc_mon_window #(.WIDTH(WIDTH)) u_window (
      .value     (v_in),
      .centre    (STEP_R),
      .tol       (TOL_R),
      .in_window (in_win)
   );

   assign measuring = (state == ST_RISE_LO) || (state == ST_RISE_HI) || (state == ST_SETTLE);
   assign accept    = start && !measuring;
   assign lo_hit    = (v_in >= LO_TH);
   assign hi_hit    = (v_in >= HI_TH);
   assign run_next  = in_win ? run + CNT_W'(1) : '0;
   assign settled   = (state == ST_SETTLE) && in_win && (run_next == RUN_DONE);
   // Completion on the last allowed sample takes priority over the timeout.
   assign expire    = measuring && (c == LAST_C) && !settled;
   assign busy      = measuring;
   assign done      = (state == ST_DONE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next-state: step through the crossings, then force DONE if the sample budget runs out.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE: if (start) state_next = ST_RISE_LO;
         ST_RISE_LO: begin
            if (lo_hit && hi_hit) state_next = ST_SETTLE;
            else if (lo_hit)      state_next = ST_RISE_HI;
         end
         ST_RISE_HI: if (hi_hit)  state_next = ST_SETTLE;
         ST_SETTLE:  if (settled) state_next = ST_DONE;
         default:                 state_next = ST_IDLE;
      endcase
      if (expire) state_next = ST_DONE;
   end

   // Sample counter, crossing and settling measurements, step drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_drive       <= '0;
         c             <= '0;
         c_lo          <= '0;
         run           <= '0;
         rise_cycles   <= '0;
         settle_cycles <= '0;
         timeout       <= 1'b0;
      end else if (accept) begin
         v_drive       <= STEP_R;
         c             <= '0;
         c_lo          <= '0;
         run           <= '0;
         rise_cycles   <= '0;
         settle_cycles <= '0;
         timeout       <= 1'b0;
      end else if (measuring) begin
         c <= c + CNT_W'(1);
         // A sample crossing both thresholds leaves rise_cycles at its cleared 0.
         if (state == ST_RISE_LO && lo_hit) c_lo <= c;
         if (state == ST_RISE_HI && hi_hit) rise_cycles <= c - c_lo;
         if (state == ST_SETTLE) begin
            run <= run_next;
            if (in_win && run == '0) settle_cycles <= c;
         end
         // On timeout only a run still alive after this sample keeps its start index.
         if (expire) begin
            timeout <= 1'b1;
            if (!(state == ST_SETTLE && in_win)) settle_cycles <= '0;
         end
      end
   end

`ifdef RC_MON_PEAK_EN
   // Running signed maximum; sample 0 seeds it so an all-negative response still reports its true peak.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                       peak <= '0;
      else if (accept)                                  peak <= '0;
      else if (measuring && (c == '0 || v_in > peak))   peak <= v_in;
   end
`else
   assign peak = '0;
`endif

endmodule

// File: tb/tb_rc_step_monitor.sv
// Self-checking bench for rc_step_monitor: directed ramps plus randomized step responses vs a scan model.
// Latency: done expected right after the edge that takes the completing sample.
// Backpressure: repeated start while busy must be ignored.
module tb_rc_step_monitor;

   localparam int W    = 24;
   localparam int STEP = 65536;
   localparam int VLO  = 6554;
   localparam int VHI  = 58982;
   localparam int VTOL = 655;
   localparam int SETC = 8;
   localparam int MAXC = 64;
   localparam int CW   = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic signed [W-1:0] v_in = '0;
   logic signed [W-1:0] v_drive;
   logic                busy, done, timeout;
   logic [CW-1:0]       rise_cycles, settle_cycles;
   logic signed [W-1:0] peak;

   int samp[128];
   int errors = 0;
   int checks = 0;

   rc_step_monitor #(
      .WIDTH(W), .EXPONENT(-16), .STEP_LEVEL(STEP), .V_LO(VLO), .V_HI(VHI), .V_TOL(VTOL),
      .SETTLE_CYCLES(SETC), .MAX_CYCLES(MAXC), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .v_in(v_in), .v_drive(v_drive), .busy(busy),
      .done(done), .timeout(timeout), .rise_cycles(rise_cycles), .settle_cycles(settle_cycles),
      .peak(peak)
   );

   always #5 clk = ~clk;

   // Ramp of +4096 per sample saturating at 1.0, optionally with one sample replaced.
   task automatic build_ramp(input int glitch_idx, input int glitch_val);
      for (int i = 0; i < 128; i++) samp[i] = (4096 * i > STEP) ? STEP : 4096 * i;
      if (glitch_idx >= 0) samp[glitch_idx] = glitch_val;
   endtask

   // Pulses start, then feeds samp[c] for sample c; returns the sample index after which done was seen.
   task automatic drive_meas(input int restart_at, output int done_at);
      done_at = -1;
      @(negedge clk); start = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 100; c++) begin
         v_in  = samp[c][W-1:0];
         start = (c == restart_at);
         @(negedge clk);
         if (done) begin
            done_at = c;
            break;
         end
      end
      start = 1'b0;
   endtask

   // Reference: scan the sample list applying the measurement rules directly.
   task automatic model_expect(output int e_end, output int e_to, output int e_rise,
                               output int e_settle, output int e_peak);
      int lo, hi, run, rs, comp, d;
      lo = -1; hi = -1; run = 0; rs = 0; comp = -1;
      for (int i = 0; i < MAXC; i++) begin
         if (lo < 0) begin
            if (samp[i] >= VLO) begin
               lo = i;
               if (samp[i] >= VHI) hi = i;
            end
         end else if (hi < 0) begin
            if (samp[i] >= VHI) hi = i;
         end else begin
            d = samp[i] - STEP;
            if (d < 0) d = -d;
            if (d <= VTOL) begin
               if (run == 0) rs = i;
               run++;
               if (run == SETC) begin
                  comp = i;
                  break;
               end
            end else begin
               run = 0;
            end
         end
      end
      e_end    = (comp >= 0) ? comp : MAXC - 1;
      e_to     = (comp < 0) ? 1 : 0;
      e_rise   = (hi >= 0) ? hi - lo : 0;
      e_settle = (comp >= 0 || run > 0) ? rs : 0;
`ifdef RC_MON_PEAK_EN
      e_peak = samp[0];
      for (int i = 1; i <= e_end; i++) if (samp[i] > e_peak) e_peak = samp[i];
`else
      e_peak = 0;
`endif
   endtask

   task automatic test_reset;
      #1;
      checks++; if (v_drive !== '0) begin errors++; $display("FAIL reset_v_drive: got %0d expected 0", v_drive); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
      checks++; if (rise_cycles !== '0 || settle_cycles !== '0) begin errors++;
         $display("FAIL reset_results: got rise=%0d settle=%0d expected 0/0", rise_cycles, settle_cycles); end
      checks++; if (peak !== '0) begin errors++; $display("FAIL reset_peak: got %0d expected 0", peak); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
         $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", busy, done); end
   endtask

   task automatic test_ramp;
      int done_at, e_peak;
      build_ramp(-1, 0);
      drive_meas(-1, done_at);
`ifdef RC_MON_PEAK_EN
      e_peak = STEP;
`else
      e_peak = 0;
`endif
      checks++; if (done_at !== 23) begin errors++; $display("FAIL ramp_done_at: got %0d expected 23", done_at); end
      checks++; if (rise_cycles !== 16'd13) begin errors++; $display("FAIL ramp_rise: got %0d expected 13", rise_cycles); end
      checks++; if (settle_cycles !== 16'd16) begin errors++; $display("FAIL ramp_settle: got %0d expected 16", settle_cycles); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL ramp_timeout: got %b expected 0", timeout); end
      checks++; if (busy !== 1'b0 || v_drive !== STEP[W-1:0]) begin errors++;
         $display("FAIL ramp_busy_drive: got busy=%b drive=%0d expected 0/%0d", busy, v_drive, STEP); end
      checks++; if (peak !== e_peak) begin errors++; $display("FAIL ramp_peak: got %0d expected %0d", peak, e_peak); end
   endtask

   task automatic test_hold_results;
      for (int k = 0; k < 5; k++) begin
         v_in = W'($urandom_range(0, 100000));
         @(negedge clk);
         checks++; if (done !== 1'b1 || rise_cycles !== 16'd13 || settle_cycles !== 16'd16 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL hold_results: got done=%b rise=%0d settle=%0d to=%b expected 1/13/16/0",
                     done, rise_cycles, settle_cycles, timeout);
         end
      end
   endtask

   task automatic test_timeout;
      int done_at;
      for (int i = 0; i < 128; i++) samp[i] = 0;
      drive_meas(-1, done_at);
      checks++; if (done_at !== MAXC - 1) begin errors++; $display("FAIL timeout_done_at: got %0d expected %0d", done_at, MAXC - 1); end
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", timeout); end
      checks++; if (rise_cycles !== '0 || settle_cycles !== '0) begin errors++;
         $display("FAIL timeout_results: got rise=%0d settle=%0d expected 0/0", rise_cycles, settle_cycles); end
      checks++; if (peak !== '0) begin errors++; $display("FAIL timeout_peak: got %0d expected 0", peak); end
   endtask

   task automatic test_glitch;
      int done_at;
      build_ramp(20, 60000);
      drive_meas(-1, done_at);
      checks++; if (done_at !== 28) begin errors++; $display("FAIL glitch_done_at: got %0d expected 28", done_at); end
      checks++; if (settle_cycles !== 16'd21) begin errors++; $display("FAIL glitch_settle: got %0d expected 21", settle_cycles); end
      checks++; if (rise_cycles !== 16'd13 || timeout !== 1'b0) begin errors++;
         $display("FAIL glitch_rise_to: got rise=%0d to=%b expected 13/0", rise_cycles, timeout); end
   endtask

   task automatic test_restart_ignored;
      int done_at;
      build_ramp(-1, 0);
      drive_meas(5, done_at);
      checks++; if (done_at !== 23) begin errors++; $display("FAIL restart_done_at: got %0d expected 23", done_at); end
      checks++; if (rise_cycles !== 16'd13 || settle_cycles !== 16'd16 || timeout !== 1'b0) begin errors++;
         $display("FAIL restart_results: got rise=%0d settle=%0d to=%b expected 13/16/0",
                  rise_cycles, settle_cycles, timeout); end
   endtask

   task automatic test_peak;
      int done_at, e_peak;
      int shape[11] = '{0, 15000, 40000, 62000, 70000, 69000, 67500, 66400, 65900, 65600, 65536};
      for (int i = 0; i < 128; i++) samp[i] = (i < 11) ? shape[i] : STEP;
      drive_meas(-1, done_at);
`ifdef RC_MON_PEAK_EN
      e_peak = 70000;
`else
      e_peak = 0;
`endif
      checks++; if (peak !== e_peak) begin errors++; $display("FAIL peak_value: got %0d expected %0d", peak, e_peak); end
      checks++; if (done_at !== 15 || rise_cycles !== 16'd2 || settle_cycles !== 16'd8) begin errors++;
         $display("FAIL peak_results: got done_at=%0d rise=%0d settle=%0d expected 15/2/8",
                  done_at, rise_cycles, settle_cycles); end
   endtask

   // Back-to-back randomized responses: each start is accepted directly from DONE.
   task automatic test_random;
      int done_at, e_end, e_to, e_rise, e_settle, e_peak;
      int slope, dly, os, mode, v;
      for (int n = 0; n < 24; n++) begin
         slope = $urandom_range(1500, 30000);
         dly   = $urandom_range(0, 6);
         os    = $urandom_range(0, 9000);
         mode  = $urandom_range(0, 9);
         for (int i = 0; i < 128; i++) begin
            if (mode == 0 || i < dly) v = int'($urandom_range(0, 4000)) - 2000;
            else if ((i - dly + 1) * slope < STEP) v = (i - dly + 1) * slope;
            else v = STEP + (os >> ((i - dly) / 2));
            if ($urandom_range(0, 15) == 0) v += int'($urandom_range(0, 3000)) - 1500;
            samp[i] = v;
         end
         model_expect(e_end, e_to, e_rise, e_settle, e_peak);
         drive_meas(-1, done_at);
         checks++; if (done_at !== e_end) begin errors++; $display("FAIL rand%0d_done_at: got %0d expected %0d", n, done_at, e_end); end
         checks++; if (timeout !== e_to[0]) begin errors++; $display("FAIL rand%0d_timeout: got %b expected %0d", n, timeout, e_to); end
         checks++; if (rise_cycles !== e_rise[CW-1:0]) begin errors++; $display("FAIL rand%0d_rise: got %0d expected %0d", n, rise_cycles, e_rise); end
         checks++; if (settle_cycles !== e_settle[CW-1:0]) begin errors++; $display("FAIL rand%0d_settle: got %0d expected %0d", n, settle_cycles, e_settle); end
         checks++; if (peak !== e_peak) begin errors++; $display("FAIL rand%0d_peak: got %0d expected %0d", n, peak, e_peak); end
      end
   endtask

   task automatic test_reset_mid;
      build_ramp(-1, 0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c <= 10; c++) begin
         v_in = samp[c][W-1:0];
         @(negedge clk);
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy: got %b expected 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (v_drive !== '0 || busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin errors++;
         $display("FAIL midreset_ctrl: got drive=%0d busy=%b done=%b to=%b expected 0/0/0/0", v_drive, busy, done, timeout); end
      checks++; if (rise_cycles !== '0 || settle_cycles !== '0 || peak !== '0) begin errors++;
         $display("FAIL midreset_results: got rise=%0d settle=%0d peak=%0d expected 0/0/0", rise_cycles, settle_cycles, peak); end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 11; c < 40; c++) begin
         v_in = samp[c][W-1:0];
         @(negedge clk);
      end
      checks++; if (busy !== 1'b0 || done !== 1'b0 || v_drive !== '0) begin errors++;
         $display("FAIL midreset_idle: got busy=%b done=%b drive=%0d expected 0/0/0", busy, done, v_drive); end
   endtask

   initial begin
      test_reset;
      test_ramp;
      test_hold_results;
      test_timeout;
      test_glitch;
      test_restart_ignored;
      test_peak;
      test_random;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
